// File: rtl/trigger_pkg.sv
// Shared definitions for the ROC token responder: ctr command codes,
// frame length and FSM state encodings.
package trigger_pkg;

  localparam logic [3:0] CMD_TRG = 4'b1000;
  localparam logic [3:0] CMD_RSR = 4'b0100;
  localparam logic [3:0] CMD_RST = 4'b0010;
  localparam logic [3:0] CMD_CAL = 4'b0001;

  // Start bit plus four payload bits.
  localparam int CTR_FRAME_LEN = 5;

  typedef enum logic {
    D_IDLE  = 1'b0,
    D_SHIFT = 1'b1
  } dec_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_HDR  = 2'd1,
    T_HITS = 2'd2,
    T_PASS = 2'd3
  } tok_state_e;

endpackage

// File: rtl/roc_ctr_decoder.sv
// Serial ctr frame decoder: start bit then 4 payload bits MSB first.
// Emits one-tick registered command strobes after the last payload bit.
module roc_ctr_decoder
  import trigger_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic       ctr,
  output logic       cmd_trg,
  output logic       cmd_rsr,
  output logic       cmd_rst,
  output logic       cmd_cal,
  output logic       cmd_inv,
  output dec_state_e state_dbg
);

  localparam logic [1:0] LAST_BIT = 2'(CTR_FRAME_LEN - 2);

  dec_state_e state, state_nxt;
  logic [1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0] shreg, shreg_nxt;
  logic [3:0] code;
  logic       done;
  logic       trg_nxt, rsr_nxt, rst_nxt, cal_nxt, inv_nxt;

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    code        = {shreg, ctr};
    done        = 1'b0;
    case (state)
      D_IDLE: begin
        if (ctr) begin
          state_nxt   = D_SHIFT;
          bit_cnt_nxt = 2'd0;
        end
      end
      D_SHIFT: begin
        shreg_nxt   = {shreg[1:0], ctr};
        bit_cnt_nxt = bit_cnt + 2'd1;
        if (bit_cnt == LAST_BIT) begin
          done      = 1'b1;
          state_nxt = D_IDLE;
        end
      end
      default: state_nxt = D_IDLE;
    endcase
    trg_nxt = done && (code == CMD_TRG);
    rsr_nxt = done && (code == CMD_RSR);
    rst_nxt = done && (code == CMD_RST);
    cal_nxt = done && (code == CMD_CAL);
    inv_nxt = done && !(trg_nxt || rsr_nxt || rst_nxt || cal_nxt);
  end

  // Strobes only move on ticks, so each lasts exactly one tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= D_IDLE;
      bit_cnt <= 2'd0;
      shreg   <= 3'd0;
      cmd_trg <= 1'b0;
      cmd_rsr <= 1'b0;
      cmd_rst <= 1'b0;
      cmd_cal <= 1'b0;
      cmd_inv <= 1'b0;
    end else if (sync) begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      cmd_trg <= trg_nxt;
      cmd_rsr <= rsr_nxt;
      cmd_rst <= rst_nxt;
      cmd_cal <= cal_nxt;
      cmd_inv <= inv_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/roc_token_responder.sv
// ROC/module emulator for the soft-TBM: queues triggers from ctr commands,
// answers each token with a modelled readout period and returns it on tout.
module roc_token_responder
  import trigger_pkg::*;
#(
  parameter int PEND_W  = 4,
  parameter int HDR_LEN = 6,
  parameter int HIT_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              ctr,
  input  logic              tin,
  output logic              tout,
  input  logic [3:0]        hits,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              cal_seen,
  output logic              cmd_err,
  output logic              tok_err,
  output tok_state_e        tok_state_dbg,
  output dec_state_e        dec_state_dbg
);

  localparam logic [7:0]        HDR_LOAD = 8'(HDR_LEN - 1);
  localparam logic [7:0]        HIT_TICK = 8'(HIT_LEN);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic cmd_trg, cmd_rsr, cmd_rst, cmd_cal, cmd_inv;

  roc_ctr_decoder u_dec (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync),
    .ctr       (ctr),
    .cmd_trg   (cmd_trg),
    .cmd_rsr   (cmd_rsr),
    .cmd_rst   (cmd_rst),
    .cmd_cal   (cmd_cal),
    .cmd_inv   (cmd_inv),
    .state_dbg (dec_state_dbg)
  );

  tok_state_e state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] hits_q, hits_q_nxt;
  logic [7:0] hit_ticks;
  logic       abort;
  logic       dec;

  assign abort     = cmd_rsr || cmd_rst;
  assign dec       = (state == T_PASS) && (pending != '0);
  assign hit_ticks = {4'd0, hits_q} * HIT_TICK;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hits_q_nxt = hits_q;
    case (state)
      T_IDLE: begin
        if (tin) begin
          state_nxt  = T_HDR;
          cnt_nxt    = HDR_LOAD;
          hits_q_nxt = hits;
        end
      end
      T_HDR: begin
        if (abort) begin
          state_nxt = T_PASS;
        end else if (cnt == 8'd0) begin
          if ((pending != '0) && (hits_q != 4'd0)) begin
            state_nxt = T_HITS;
            cnt_nxt   = hit_ticks - 8'd1;
          end else begin
            state_nxt = T_PASS;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      T_HITS: begin
        if (abort || (cnt == 8'd0)) begin
          state_nxt = T_PASS;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      T_PASS:  state_nxt = T_IDLE;
      default: state_nxt = T_IDLE;
    endcase
  end

  // busy/tout are registered views of the current state, so they trail it by one tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= T_IDLE;
      cnt      <= 8'd0;
      hits_q   <= 4'd0;
      tout     <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
      cal_seen <= 1'b0;
      cmd_err  <= 1'b0;
      tok_err  <= 1'b0;
    end else if (sync) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hits_q   <= hits_q_nxt;
      tout     <= (state == T_PASS);
      busy     <= (state != T_IDLE);
      cal_seen <= cmd_cal;

      if (abort) begin
        pending <= '0;
      end else if (cmd_trg && !dec) begin
        if (pending == PEND_MAX) overflow <= 1'b1;
        else                     pending  <= pending + PEND_ONE;
      end else if (dec && !cmd_trg) begin
        pending <= pending - PEND_ONE;
      end

      if (cmd_inv) cmd_err <= 1'b1;
      if (cmd_rst) begin
        overflow <= 1'b0;
        cmd_err  <= 1'b0;
        tok_err  <= 1'b0;
      end
      if (tin && (state != T_IDLE)) tok_err <= 1'b1;
    end
  end

  assign tok_state_dbg = state;

endmodule

// File: tb/tb_roc_token_responder.sv
// Randomized and directed bench for roc_token_responder against a
// tick-scheduled reference model of the ctr protocol and token timing.
module tb_roc_token_responder;
  import trigger_pkg::*;

  localparam int HDR_LEN  = 6;
  localparam int HIT_LEN  = 3;
  localparam int PEND_MAX = 15;

  localparam logic [3:0] C_TRG = 4'b1000;
  localparam logic [3:0] C_RSR = 4'b0100;
  localparam logic [3:0] C_RST = 4'b0010;
  localparam logic [3:0] C_CAL = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic       sync;
  logic       ctr;
  logic       tin;
  logic [3:0] hits;
  logic       tout, busy, overflow, cal_seen, cmd_err, tok_err;
  logic [3:0] pending;
  logic [1:0] tok_dbg;
  logic       dec_dbg;

  roc_token_responder #(.PEND_W(4), .HDR_LEN(HDR_LEN), .HIT_LEN(HIT_LEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .sync          (sync),
    .ctr           (ctr),
    .tin           (tin),
    .tout          (tout),
    .hits          (hits),
    .busy          (busy),
    .pending       (pending),
    .overflow      (overflow),
    .cal_seen      (cal_seen),
    .cmd_err       (cmd_err),
    .tok_err       (tok_err),
    .tok_state_dbg (tok_dbg),
    .dec_state_dbg (dec_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, tick_no);
    end
  endtask

  typedef struct {
    int         t;
    logic [3:0] c;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [3:0]  frame_q[$];
  logic [31:0] exp_q[$];     // ticks at which a returned token is expected
  logic [3:0]  cur_code;
  int          bit_idx  = 0;
  int          tick_no  = 0;
  int          tout_cnt = 0;
  int          cal_cnt  = 0;
  int          last_tout_tick = -1;

  // ---------------- reference model ----------------
  int         m_pending;
  logic       m_overflow, m_cmd_err, m_tok_err, m_cal, m_tout, m_busy;
  bit         m_active;
  int         m_hdr_end, m_pass_tick;
  logic [3:0] m_hits;

  task automatic model_reset();
    m_pending = 0; m_overflow = 0; m_cmd_err = 0; m_tok_err = 0;
    m_cal = 0; m_tout = 0; m_busy = 0; m_active = 0;
    m_hdr_end = 0; m_pass_tick = 0; m_hits = 0;
    cmd_q.delete();
    frame_q.delete();
    bit_idx = 0;
  endtask

  // A command executes five ticks after its start bit is driven.
  function automatic logic gen_ctr();
    logic b;
    b = 1'b0;
    if (bit_idx == 0) begin
      if (frame_q.size() > 0) begin
        cur_code = frame_q.pop_front();
        cmd_q.push_back('{t: tick_no + 5, c: cur_code});
        bit_idx = 1;
        b = 1'b1;
      end
    end else begin
      b = cur_code[4 - bit_idx];
      bit_idx = (bit_idx == 4) ? 0 : bit_idx + 1;
    end
    return b;
  endfunction

  task automatic model_step(input logic t, input logic [3:0] h);
    logic [3:0] code;
    bit has_cmd, is_trg, is_rsr, is_rst, is_cal, is_inv, pass_now, dc, old_active;
    int old_pending;
    int n;
    n = tick_no;
    has_cmd = 0;
    code = 4'd0;
    if (cmd_q.size() > 0 && cmd_q[0].t == n) begin
      code = cmd_q[0].c;
      has_cmd = 1;
      cmd_q.delete(0);
    end
    is_trg = has_cmd && code == C_TRG;
    is_rsr = has_cmd && code == C_RSR;
    is_rst = has_cmd && code == C_RST;
    is_cal = has_cmd && code == C_CAL;
    is_inv = has_cmd && !(is_trg || is_rsr || is_rst || is_cal);

    old_active  = m_active;
    old_pending = m_pending;
    pass_now    = m_active && (n == m_pass_tick);
    dc          = pass_now && (old_pending > 0);

    if (pass_now) begin
      m_active = 0;
      exp_q.push_back(n);
    end else if (m_active) begin
      if (is_rsr || is_rst) m_pass_tick = n + 1;
      else if (n == m_hdr_end && old_pending > 0 && m_hits > 0)
        m_pass_tick = n + 1 + m_hits * HIT_LEN;
    end
    if (t && !old_active) begin
      m_active    = 1;
      m_hits      = h;
      m_hdr_end   = n + HDR_LEN;
      m_pass_tick = n + 1 + HDR_LEN;
    end

    if (is_rsr || is_rst) m_pending = 0;
    else if (is_trg && !dc) begin
      if (old_pending == PEND_MAX) m_overflow = 1;
      else m_pending = old_pending + 1;
    end else if (dc && !is_trg) m_pending = old_pending - 1;

    if (is_inv) m_cmd_err = 1;
    if (is_rst) begin m_overflow = 0; m_cmd_err = 0; m_tok_err = 0; end
    if (t && old_active) m_tok_err = 1;

    m_tout = pass_now;
    m_busy = old_active;
    m_cal  = is_cal;
  endtask

  task automatic check_outputs(input string p);
    check({p, "_tout"},     tout,     m_tout);
    check({p, "_busy"},     busy,     m_busy);
    check({p, "_pending"},  pending,  m_pending);
    check({p, "_overflow"}, overflow, m_overflow);
    check({p, "_cal_seen"}, cal_seen, m_cal);
    check({p, "_cmd_err"},  cmd_err,  m_cmd_err);
    check({p, "_tok_err"},  tok_err,  m_tok_err);
  endtask

  // ---------------- driver tasks ----------------
  // One off-phase clock with noisy inputs (must be ignored), then one tick.
  task automatic tick(input logic t, input logic [3:0] h);
    logic c;
    @(negedge clk);
    sync = 1'b0; ctr = 1'($urandom); tin = 1'($urandom); hits = 4'($urandom);
    @(posedge clk); #1;
    check_outputs("hold");
    c = gen_ctr();
    @(negedge clk);
    sync = 1'b1; ctr = c; tin = t; hits = h;
    @(posedge clk); #1;
    model_step(t, h);
    check_outputs("tick");
    if (tout === 1'b1) begin
      tout_cnt++;
      last_tout_tick = tick_no;
      if (exp_q.size() == 0) check("tout_extra", 1, 0);
      else                   check("tout_when", tick_no, exp_q.pop_front());
    end
    if (cal_seen === 1'b1) cal_cnt++;
    tick_no++;
  endtask

  task automatic idle_ticks(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 4'($urandom));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((frame_q.size() > 0 || bit_idx != 0 || cmd_q.size() > 0) && guard < 200) begin
      tick(1'b0, 4'($urandom));
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 1, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_tout", tout, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    check("rst_cal_seen", cal_seen, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_tok_err", tok_err, 0);
    check("rst_tok_state", tok_dbg, T_IDLE);
    check("rst_dec_state", dec_dbg, D_IDLE);
    model_reset();
    repeat (3) @(negedge clk);
    sync = 1'b0; ctr = 1'b0; tin = 1'b0;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, c0, p0, r;
    reset = 1'b0; sync = 1'b0; ctr = 1'b0; tin = 1'b0; hits = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    async_reset();

    // 1: single trigger, empty event
    frame_q.push_back(C_TRG);
    drain();
    check("t1_pending", pending, 1);
    t0 = tick_no; last_tout_tick = -1;
    tick(1'b1, 4'd0);
    idle_ticks(10);
    check("t1_latency", last_tout_tick - t0, 7);
    check("t1_pending_after", pending, 0);

    // 2: three triggers, two hits
    repeat (3) frame_q.push_back(C_TRG);
    drain();
    check("t2_pending", pending, 3);
    t0 = tick_no; last_tout_tick = -1;
    tick(1'b1, 4'd2);
    idle_ticks(16);
    check("t2_latency", last_tout_tick - t0, 13);
    check("t2_pending_after", pending, 2);

    // 3: saturation and rst
    frame_q.push_back(C_RST);
    repeat (16) frame_q.push_back(C_TRG);
    drain();
    check("t3_pending_sat", pending, 15);
    check("t3_overflow", overflow, 1);
    frame_q.push_back(C_RST);
    drain();
    check("t3_pending_rst", pending, 0);
    check("t3_overflow_rst", overflow, 0);

    // 4: rsr aborts a readout during the hit phase
    frame_q.push_back(C_TRG);
    drain();
    t0 = tick_no; last_tout_tick = -1;
    tick(1'b1, 4'd5);
    idle_ticks(6);
    frame_q.push_back(C_RSR);
    idle_ticks(12);
    check("t4_latency", last_tout_tick - t0, 13);
    check("t4_pending", pending, 0);
    check("t4_tok_err", tok_err, 0);

    // 5: invalid code then cal
    p0 = m_pending; c0 = cal_cnt;
    frame_q.push_back(4'b0110);
    frame_q.push_back(C_CAL);
    drain();
    idle_ticks(2);
    check("t5_cmd_err", cmd_err, 1);
    check("t5_pending", pending, p0);
    check("t5_cal_pulses", cal_cnt - c0, 1);

    // 6: token while busy, then reset during a readout
    c0 = tout_cnt;
    tick(1'b1, 4'd0);
    idle_ticks(3);
    tick(1'b1, 4'd0);
    idle_ticks(20);
    check("t6_tok_err", tok_err, 1);
    check("t6_one_tout", tout_cnt - c0, 1);
    c0 = tout_cnt;
    tick(1'b1, 4'd0);
    idle_ticks(4);
    async_reset();
    idle_ticks(15);
    check("t6_no_tout_after_reset", tout_cnt - c0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (frame_q.size() == 0 && $urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 99);
        if      (r < 40) frame_q.push_back(C_TRG);
        else if (r < 48) frame_q.push_back(C_CAL);
        else if (r < 52) frame_q.push_back(C_RSR);
        else if (r < 55) frame_q.push_back(C_RST);
        else             frame_q.push_back(4'($urandom));
      end
      if ($urandom_range(0, 599) == 0) async_reset();
      tick(1'($urandom_range(0, 9) == 0), 4'($urandom));
    end
    idle_ticks(60);
    check("tout_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
